// File: rtl/demux_route_buf_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_route_buf_if                                                       |
// | Handshake bundle for the 1-to-2 routing demux: one input stream, two     |
// | buffered output streams. DEMUX_ROUTE_CNT_EN adds per-output pop counters.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface demux_route_buf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sel;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [DATA_WIDTH-1:0] b_data;
    logic [1:0]            a_count;
    logic [1:0]            b_count;
`ifdef DEMUX_ROUTE_CNT_EN
    logic [15:0]           a_xfer_cnt;
    logic [15:0]           b_xfer_cnt;
`endif

    // slave = the demux itself, master = the producer/consumers around it
    modport slave (
        input  in_valid, in_sel, in_data, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
`ifdef DEMUX_ROUTE_CNT_EN
        , output a_xfer_cnt, b_xfer_cnt
`endif
    );

    modport master (
        output in_valid, in_sel, in_data, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
`ifdef DEMUX_ROUTE_CNT_EN
        , input a_xfer_cnt, b_xfer_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/demux_route_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_route_buf                                                          |
// | 1-to-2 registered demux with a 2-entry FIFO per output.                  |
// | Optional macro DEMUX_ROUTE_CNT_EN: 16-bit completed-pop counter per out. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module demux_route_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    demux_route_buf_if.slave    bus
);
    logic [1:0]            w_full;
    logic [1:0]            w_valid;
    logic [1:0]            w_ready;
    logic [DATA_WIDTH-1:0] w_data  [2];
    logic [1:0]            w_count [2];
    logic                  w_in_ready;
`ifdef DEMUX_ROUTE_CNT_EN
    logic [15:0]           w_xfer_cnt [2];
`endif

    assign w_ready    = {bus.b_ready, bus.a_ready};
    // Acceptance depends only on registered occupancy, never on consumer readies
    assign w_in_ready = ~w_full[bus.in_sel];

    for (genvar k = 0; k < 2; k++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem_q [2];
        logic                  rd_ptr_q;
        logic                  wr_ptr_q;
        logic [1:0]            count_q;
        logic [1:0]            count_d;
        logic                  push;
        logic                  pop;

        assign push = bus.in_valid & w_in_ready & (bus.in_sel == 1'(k));
        assign pop  = (count_q != 2'd0) & w_ready[k];

        always_comb begin
            count_d = count_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                mem_q[0] <= '0;
                mem_q[1] <= '0;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= bus.in_data;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                count_q <= count_d;
            end
        end

        assign w_full[k]  = (count_q == 2'd2);
        assign w_valid[k] = (count_q != 2'd0);
        assign w_data[k]  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
        assign w_count[k] = count_q;

`ifdef DEMUX_ROUTE_CNT_EN
        logic [15:0] xfer_cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                xfer_cnt_q <= 16'd0;
            end else if (pop) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
        end

        assign w_xfer_cnt[k] = xfer_cnt_q;
`endif
    end

    assign bus.in_ready = w_in_ready;
    assign bus.a_valid  = w_valid[0];
    assign bus.a_data   = w_data[0];
    assign bus.a_count  = w_count[0];
    assign bus.b_valid  = w_valid[1];
    assign bus.b_data   = w_data[1];
    assign bus.b_count  = w_count[1];
`ifdef DEMUX_ROUTE_CNT_EN
    assign bus.a_xfer_cnt = w_xfer_cnt[0];
    assign bus.b_xfer_cnt = w_xfer_cnt[1];
`endif
endmodule
`default_nettype wire
